lsu_master: RTL

- Load/store initiator sitting between the pipeline MEM stage and the byte-addressed, little-endian data memory.
- The data memory exposes one combinational 32-bit read port (RD from address A) and one 32-bit write port (WD, WE, committed at the clock edge, bytes A..A+3).
- This block accepts RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) with a valid/ready handshake.
- Loads: sequences the memory access, then extracts and sign/zero-extends the result.
- Sub-word stores: performed as read-modify-write, because the memory only writes whole 4-byte groups.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 45 ++++
 rtl/lsu_master.sv | 112 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store initiator
// Purpose: FSM state encoding, RV32I load/store funct3 codes and the
//          funct3 legality check used by lsu_master.
// Ports:   none (package).
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only come in B/H/W; loads additionally have the unsigned B/H forms.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (we) begin
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extraction for loads and read-modify-write merge for stores
// Purpose: purely combinational data shaping. Lanes are always the low bytes
//          because the memory returns bytes A..A+3 for address A.
// Ports:   funct3     in  access size/sign
//          rdata      in  word read from memory
//          wdata      in  store data from the request
//          load_data  out extracted, sign/zero-extended load result
//          store_data out word to write back to memory
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int D_WIDTH = 8
) (
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rdata,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] store_data
);

  localparam int H_WIDTH = 2 * D_WIDTH;

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{(WIDTH-D_WIDTH){rdata[D_WIDTH-1]}}, rdata[D_WIDTH-1:0]};
      F3_H:    load_data = {{(WIDTH-H_WIDTH){rdata[H_WIDTH-1]}}, rdata[H_WIDTH-1:0]};
      F3_BU:   load_data = {{(WIDTH-D_WIDTH){1'b0}}, rdata[D_WIDTH-1:0]};
      F3_HU:   load_data = {{(WIDTH-H_WIDTH){1'b0}}, rdata[H_WIDTH-1:0]};
      default: load_data = rdata;
    endcase
  end

  // Sub-word stores keep the upper bytes that were just read back.
  always_comb begin
    store_data = wdata;
    case (funct3)
      F3_B:    store_data = {rdata[WIDTH-1:D_WIDTH], wdata[D_WIDTH-1:0]};
      F3_H:    store_data = {rdata[WIDTH-1:H_WIDTH], wdata[H_WIDTH-1:0]};
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// rtl/lsu_master.sv - RV32I load/store initiator between MEM stage and data memory
// Purpose: accepts one load/store request at a time, sequences the memory
//          access (read-modify-write for SB/SH) and returns a one-cycle response.
// Option:  define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses with
//          resp_err instead of performing them at the byte address.
// Ports:   CLK, RST                    clock, synchronous active-high reset
//          req_valid/req_ready         request handshake
//          req_we/req_funct3/req_addr/req_wdata  request fields
//          resp_valid/resp_data/resp_err          response (one-cycle pulse)
//          mem_A/mem_WD/mem_WE/mem_RD   data memory port (combinational read)
module lsu_master
  import lsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int D_WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic [WIDTH-1:0] mem_A,
  output logic [WIDTH-1:0] mem_WD,
  output logic             mem_WE,
  input  logic [WIDTH-1:0] mem_RD
);

  lsu_state_t       state;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic [2:0]       funct3_q;
  logic             we_q;
  logic             err_q;
  logic             misalign;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] store_data;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                    ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            if (!is_legal(req_we, req_funct3) || misalign) begin
              err_q <= 1'b1;
              state <= RESP;
            end else if (req_we && (req_funct3 == F3_W)) begin
              err_q <= 1'b0;
              state <= WRITE;
            end else begin
              // Loads and sub-word stores both need the current word first.
              err_q <= 1'b0;
              state <= READ;
            end
          end
        end
        READ: begin
          rdata_q <= mem_RD;
          state   <= we_q ? WRITE : RESP;
        end
        WRITE:   state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  lsu_align #(
    .WIDTH   (WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_align (
    .funct3     (funct3_q),
    .rdata      (rdata_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // Outputs are gated with !RST so an aborted access neither writes nor responds.
  assign req_ready  = (state == IDLE) && !RST;
  assign resp_valid = (state == RESP) && !RST;
  assign resp_err   = resp_valid && err_q;
  assign resp_data  = (resp_valid && !err_q && !we_q) ? load_data : '0;
  assign mem_A      = addr_q;
  assign mem_WE     = (state == WRITE) && !RST;
  assign mem_WD     = (state == WRITE) ? store_data : '0;

endmodule
